// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port word memory.
package mem_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    INIT,
    RUN
  } mem_state_t;

  // Byte-lane merge: keep the old byte unless its enable is set.
  function automatic logic [BYTE_W-1:0] merge_byte(input logic [BYTE_W-1:0] old_b,
                                                   input logic [BYTE_W-1:0] new_b,
                                                   input logic              en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mem_init_ctrl.sv
// Post-reset sweep controller: walks the array once writing zeros, then
// raises ready for normal operation.
module mem_init_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH         = 4096,
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter int unsigned IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  output logic             init_we,
  output logic [IDX_W-1:0] init_addr
);

  localparam mem_state_t       RESET_ST = INIT_ON_RESET ? INIT : RUN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  mem_state_t       r_state;
  mem_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic             r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      INIT: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = RESET_ST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_ST;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == RUN);
    end
  end

  assign ready     = r_ready;
  assign init_we   = (r_state == INIT);
  assign init_addr = r_cnt;

endmodule

// File: rtl/dual_port_memory.sv
// Shared word array with a byte-writable data port and a read-only fetch port;
// both ports have one-cycle registered reads and a valid strobe.
module dual_port_memory
  import mem_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DEPTH         = 4096,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         ready,
  input  logic                         if_req,
  input  logic [ADDR_WIDTH-1:0]        pc,
  output logic [WORD_WIDTH-1:0]        instr,
  output logic                         instr_valid,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [WORD_WIDTH/BYTE_W-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]        data_addr,
  input  logic [WORD_WIDTH-1:0]        data_in,
  output logic [WORD_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic                         data_err
);

  localparam int unsigned           LANES   = WORD_WIDTH / BYTE_W;
  localparam int unsigned           IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  logic             w_ready;
  logic             w_init_we;
  logic [IDX_W-1:0] w_init_addr;

  mem_init_ctrl #(
    .DEPTH         (DEPTH),
    .INIT_ON_RESET (INIT_ON_RESET),
    .IDX_W         (IDX_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (w_ready),
    .init_we   (w_init_we),
    .init_addr (w_init_addr)
  );

  logic             w_pc_ok;
  logic             w_d_ok;
  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_d_idx;
  logic             w_if_acc;
  logic             w_d_acc;

  assign w_pc_ok  = ({1'b0, pc} < DEPTH_L);
  assign w_d_ok   = ({1'b0, data_addr} < DEPTH_L);
  assign w_pc_idx = pc[IDX_W-1:0];
  assign w_d_idx  = data_addr[IDX_W-1:0];
  assign w_if_acc = w_ready & if_req;
  assign w_d_acc  = w_ready & d_req;

  logic                  w_we;
  logic [IDX_W-1:0]      w_waddr;
  logic [WORD_WIDTH-1:0] w_wdata;
  logic [LANES-1:0]      w_wbe;

  // The sweep owns the write port until ready rises.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_d_idx;
    w_wdata = data_in;
    w_wbe   = d_be;
    if (w_init_we) begin
      w_we    = 1'b1;
      w_waddr = w_init_addr;
      w_wdata = '0;
      w_wbe   = '1;
    end else if (w_d_acc && d_we && w_d_ok) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        r_mem[w_waddr][i*BYTE_W +: BYTE_W] <= merge_byte(r_mem[w_waddr][i*BYTE_W +: BYTE_W],
                                                         w_wdata[i*BYTE_W +: BYTE_W],
                                                         w_wbe[i]);
      end
    end
  end

  logic [WORD_WIDTH-1:0] r_instr;
  logic                  r_instr_valid;
  logic [WORD_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_data_err;

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_data_err    <= 1'b0;
    end else begin
      r_instr_valid <= w_if_acc;
      r_data_valid  <= w_d_acc & ~d_we;
      r_data_err    <= w_d_acc & ~w_d_ok;
      if (w_if_acc) begin
        r_instr <= w_pc_ok ? r_mem[w_pc_idx] : '0;
      end
      if (w_d_acc && !d_we) begin
        r_data_out <= w_d_ok ? r_mem[w_d_idx] : '0;
      end
    end
  end

  assign ready       = w_ready;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign data_err    = r_data_err;

endmodule

// File: tb/tb_dual_port_memory.sv
// Scoreboard bench for dual_port_memory with DEPTH = 16 and the reset sweep on.
module tb_dual_port_memory;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        if_req;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_be;
  logic [15:0] data_addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_err;

  dual_port_memory #(
    .WORD_WIDTH    (16),
    .ADDR_WIDTH    (16),
    .DEPTH         (16),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ready       (ready),
    .if_req      (if_req),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_be        (d_be),
    .data_addr   (data_addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_err    (data_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] q_i [$];
  logic [16:0] q_d [$];   // {expected err, expected data}
  int          werr_pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got pulse with value 0x%0h, required no pulse", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    logic [15:0] ei;
    logic [16:0] ed;
    if (rst_n) begin
      if (instr_valid) begin
        if (q_i.size() == 0) bad("instr_extra", 32'(instr));
        else begin
          ei = q_i.pop_front();
          chk("instr", 32'(instr), 32'(ei));
        end
      end
      if (data_valid) begin
        if (q_d.size() == 0) bad("data_extra", 32'(data_out));
        else begin
          ed = q_d.pop_front();
          chk("data_out", 32'(data_out), 32'(ed[15:0]));
          chk("data_err_rd", 32'(data_err), 32'(ed[16]));
        end
      end else if (data_err) begin
        if (werr_pending == 0) bad("data_err_extra", 32'(data_err));
        else begin
          werr_pending--;
          vectors++;
        end
      end
    end
  end

  task automatic drive(input logic ifr, input logic [15:0] p, input logic dr, input logic we,
                       input logic [1:0] be, input logic [15:0] a, input logic [15:0] d);
    if_req = ifr; pc = p; d_req = dr; d_we = we; d_be = be; data_addr = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b0, 16'h0, 1'b1, 1'b1, be, a, d);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input logic err);
    q_d.push_back({err, exp});
    drive(1'b0, 16'h0, 1'b1, 1'b0, 2'b00, a, 16'h0);
  endtask

  task automatic fetch(input logic [15:0] p, input logic [15:0] exp);
    q_i.push_back(exp);
    drive(1'b1, p, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_pc [4];
  logic [15:0] exp_dr [4];
  int n;

  initial begin
    rst_n = 1'b1;
    if_req = 1'b0; pc = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; data_addr = '0; data_in = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_data_err", 32'(data_err), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_data_out", 32'(data_out), 0);
    #10 rst_n = 1'b1;

    wait_ready(n);
    chk("ready_latency", 32'(n), 16);

    // Sweep zeroed every word; fetch and data ports read concurrently.
    for (int i = 0; i < 16; i++) begin
      q_i.push_back(16'h0);
      q_d.push_back({1'b0, 16'h0});
      drive(1'b1, 16'(i), 1'b1, 1'b0, 2'b00, 16'(i), 16'h0);
    end
    idle();

    // Out-of-range write aliases to index 0 if not dropped.
    werr_pending++;
    wr(16'd16, 16'hBEEF, 2'b11);
    idle();
    idle();
    rd(16'd0, 16'h0000, 1'b0);
    rd(16'd18, 16'h0000, 1'b1);
    fetch(16'd20, 16'h0000);

    // Byte-lane merge.
    wr(16'd5, 16'hABCD, 2'b11);
    wr(16'd5, 16'h1200, 2'b10);
    rd(16'd5, 16'h12CD, 1'b0);
    wr(16'd7, 16'h00FF, 2'b01);
    rd(16'd7, 16'h00FF, 1'b0);

    // Read-first on a same-cycle write and fetch.
    wr(16'd3, 16'h1111, 2'b11);
    q_i.push_back(16'h1111);
    drive(1'b1, 16'd3, 1'b1, 1'b1, 2'b11, 16'd3, 16'h5555);
    fetch(16'd3, 16'h5555);

    // Zero byte-enable write is a no-op.
    wr(16'd8, 16'h8008, 2'b11);
    wr(16'd8, 16'hFFFF, 2'b00);
    rd(16'd8, 16'h8008, 1'b0);

    wr(16'd0, 16'hA000, 2'b11);
    wr(16'd1, 16'hA001, 2'b11);
    wr(16'd2, 16'hA002, 2'b11);
    wr(16'd9, 16'h9009, 2'b11);
    wr(16'd10, 16'hA00A, 2'b11);
    wr(16'd11, 16'hB00B, 2'b11);
    exp_pc = '{16'hA000, 16'hA001, 16'hA002, 16'h5555};
    exp_dr = '{16'h8008, 16'h9009, 16'hA00A, 16'hB00B};
    for (int i = 0; i < 4; i++) begin
      q_i.push_back(exp_pc[i]);
      q_d.push_back({1'b0, exp_dr[i]});
      drive(1'b1, 16'(i), 1'b1, 1'b0, 2'b00, 16'(8 + i), 16'h0);
    end
    idle();
    idle();
    chk("q_i_drained_1", 32'(q_i.size()), 0);
    chk("q_d_drained_1", 32'(q_d.size()), 0);

    // Reset mid-sweep: outputs clear and the sweep restarts from zero.
    rst_n = 1'b0;
    #3;
    chk("rst2_instr", 32'(instr), 0);
    chk("rst2_data_out", 32'(data_out), 0);
    chk("rst2_ready", 32'(ready), 0);
    rst_n = 1'b1;
    n = 0;
    while (n < 7) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    #5 rst_n = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      if_req = 1'b1; pc = 16'd5; d_req = 1'b1; d_be = 2'b11; data_in = 16'h7777;
      d_we = (n >= 8);
      data_addr = (n >= 8) ? 16'd2 : 16'd18;
      @(posedge clk);
      #1;
      n++;
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk("ready_latency_restart", 32'(n), 16);
    rd(16'd2, 16'h0000, 1'b0);
    rd(16'd9, 16'h0000, 1'b0);
    fetch(16'd0, 16'h0000);
    idle();
    idle();
    idle();
    chk("q_i_drained_2", 32'(q_i.size()), 0);
    chk("q_d_drained_2", 32'(q_d.size()), 0);
    chk("werr_drained", 32'(werr_pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dual_port_memory.md
# dual_port_memory

Parametrised successor to the single-cycle combinational-read word memory: one write-capable data port and one read-only instruction-fetch port over a shared word array. Both ports have registered reads with request/valid handshakes, and the data port has per-byte write enables. After reset, an optional hardware sweep zeroes the whole array, and out-of-range accesses are flagged. The block sits between the CPU core's fetch and load/store stages and replaces the unclocked-read memory in the top level.

## Interface
- `WORD_WIDTH`, 16: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 16: width of both address ports.
- `DEPTH`, 4096: number of words; must be ≤ 2^ADDR_WIDTH.
- `INIT_ON_RESET`, 1: when 1, the block zeroes the array after reset; when 0, it skips the sweep.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ready` out 1: high when the block accepts requests.
- `if_req` in 1: instruction fetch request.
- `pc` in ADDR_WIDTH: fetch address.
- `instr` out WORD_WIDTH: fetched word.
- `instr_valid` out 1: `instr` is valid this cycle.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_be` in WORD_WIDTH/8: byte-lane write enables; bit i covers bits [8i+7:8i].
- `data_addr` in ADDR_WIDTH: data address.
- `data_in` in WORD_WIDTH: write data.
- `data_out` out WORD_WIDTH: read data.
- `data_valid` out 1: `data_out` is valid (reads only).
- `data_err` out 1: one-cycle pulse for an out-of-range data access.

## Operation
- States: INIT and RUN.
  - Reset enters INIT if `INIT_ON_RESET` = 1, otherwise RUN.
  - INIT writes 0 to one address per cycle, 0 through DEPTH−1, using an internal counter.
  - After writing DEPTH−1, the block moves to RUN.
- `ready` = (state == RUN), registered.
- Requests seen while `ready` = 0 are dropped silently: no valid pulse, no err pulse, no write.
- Fetch (RUN, `if_req` = 1): `instr` ← mem[pc] and `instr_valid` = 1 on the next cycle.
  - `pc` ≥ DEPTH returns 0 with `instr_valid` = 1. There is no fetch error output.
- Data read (RUN, `d_req` = 1, `d_we` = 0): `data_out` ← mem[data_addr] and `data_valid` = 1 on the next cycle.
- Data write (RUN, `d_req` = 1, `d_we` = 1): only lanes with `d_be`[i] = 1 are updated; other lanes keep their old value. No `data_valid` is produced.
  - `d_be` = 0 is a legal no-op write.
- Out of range (`data_addr` ≥ DEPTH):
  - Writes are dropped.
  - Reads return 0 with `data_valid` = 1.
  - `data_err` = 1 on the next cycle in both cases.
- A write and a fetch to the same address in the same cycle are read-first: `instr` returns the old word.
- A data read the cycle after a write to the same address returns the new word.
- `instr` and `data_out` hold their last value when no request is made. The valid outputs drop to 0.
- Reset clears the FSM, the counter and all output registers. Array contents are not reset asynchronously.

## Timing
- Reset values: `ready`, `instr_valid`, `data_valid` and `data_err` = 0; `instr` and `data_out` = 0.
- With `INIT_ON_RESET` = 1:
  - Address 0 is cleared on the first rising edge after `rst_n` deasserts.
  - Address DEPTH−1 is cleared on edge DEPTH.
  - `ready` = 1 after edge DEPTH.
- With `INIT_ON_RESET` = 0: `ready` = 1 after the first edge following reset release.
- If `rst_n` asserts during INIT, the sweep restarts from address 0 when reset is released.
- Read latency is 1 cycle on both ports; throughput is one request per port per cycle, back to back.
- The two ports are independent. A fetch and a data access may issue in the same cycle with no stall.

## Structure
- Shared package `mem_pkg`:
  - state enum `mem_state_t` {INIT, RUN};
  - constant `BYTE_W` = 8;
  - helper function for byte-lane merging.
- Sub-module `mem_init_ctrl` owns the FSM, the address counter and `ready`. The top level muxes its write port onto the array during INIT.
- The array is inferred as true dual-port RAM with one write port.

## Test plan
- Reset with DEPTH = 16, `INIT_ON_RESET` = 1 → `ready` rises exactly 16 cycles after reset release; a read of every address returns 0.
- Write 0xABCD to address 5 with `d_be` = 2'b11, then write 0x1200 with `d_be` = 2'b10 → a read of address 5 returns 0x12CD one cycle after the request.
- Same cycle: write 0x5555 to address 3 (old value 0x1111) and fetch `pc` = 3 → `instr` = 0x1111; the next fetch returns 0x5555.
- Write to address DEPTH → `data_err` pulses for one cycle, no array word changes, no `data_valid`. A read of address DEPTH+2 → `data_out` = 0, `data_valid` = 1, `data_err` = 1.
- Assert `rst_n` low at sweep address 7, then release → `ready` stays 0 for 16 more cycles; requests issued while `ready` = 0 produce no valid pulses.
- Back-to-back fetches of `pc` 0..3 with concurrent data reads of 8..11 → 4 consecutive `instr_valid` and `data_valid` pulses carrying the correct words in order.
